note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Upstream feeder of the note-change controller in the music-player datapath.
- Walks a synchronous song ROM one word per note and decodes each word into a beat duration (BDN) for the note-change controller and a tone divisor for the tone generator.
- Advances to the next note on each rising edge of the controller's cp pulse.
- Handles start/stop, end-of-song marker, optional looping and address wrap.

Parameters:
- ADDR_W, 5, song ROM address width.
- SONG_LEN, 32, number of ROM words used; address wraps after SONG_LEN-1.
- CLK_HZ, 50000000, system clock frequency used for the tone divisor table.
- TONE_W, 18, tone divisor width.

Ports:
- clk  in  1  system clock; the single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; begins playback from address 0 when sampled in IDLE or DONE.
- stop  in  1  level; aborts playback.
- loop_en  in  1  replay from address 0 on end marker.
- cp  in  1  note-change pulse from the note-change controller.
- rom_addr  out  ADDR_W  song ROM address.
- rom_data  in  8  ROM word; valid one clk after rom_addr.
- BDN  out  6  beat duration number to the note-change controller.
- tone_div  out  TONE_W  half-period count for the tone generator.
- mute  out  1  1 = silence the tone generator.
- playing  out  1  high in FETCH, LOAD and PLAY.
- done  out  1  high in DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, rom_addr=0, BDN=0, tone_div=0, mute=1, playing=0, done=0, cp_d=0.
- cp edge detection: cp_d registers cp each clk; cp_rise = cp & ~cp_d. Only cp_rise is acted on, so a multi-cycle cp advances one note.
- ROM word fields:
  - [7:4] note code: 0 = rest; 1..12 = C4..B4; 13..15 = rest.
  - [3] reserved, ignored.
  - [2:0] beat code: 0 = end marker.
- BDN decode for beat codes 1..7: 1, 2, 3, 4, 6, 8, 16.
- tone_div decode: CLK_HZ/(2*f), truncated, computed as elaborate-time constants.
  - f = 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494 Hz for codes 1..12.
  - Rest: tone_div=0, mute=1. Any other note: mute=0.
- States:
  - IDLE: start -> FETCH with rom_addr=0.
  - FETCH: rom_addr presented; unconditionally -> LOAD next clk.
  - LOAD: rom_data sampled.
    - End marker with loop_en=1: rom_addr=0 -> FETCH.
    - End marker with loop_en=0: -> DONE, mute=1, BDN=0.
    - Otherwise: register BDN, tone_div and mute -> PLAY.
  - PLAY: cp_rise -> rom_addr = (rom_addr==SONG_LEN-1) ? 0 : rom_addr+1 -> FETCH. BDN, tone_div and mute hold until the next LOAD.
  - DONE: start -> FETCH with rom_addr=0; otherwise hold.
- Latency:
  - cp_rise sampled at edge n; FETCH during cycle n+1; outputs update at edge n+2.
  - Start sampled at edge n; first note outputs valid after edge n+2.
- Boundary conditions:
  - cp_rise in IDLE, FETCH, LOAD or DONE is ignored.
  - start in FETCH, LOAD or PLAY is ignored.
  - stop in any state -> IDLE next clk with mute=1, BDN=0, tone_div=0, rom_addr=0. Stop wins over simultaneous start or cp_rise.
  - reset mid-note behaves as stop and also clears cp_d.
  - Address wrap with no end marker continues playing from address 0.

Optional Feature:
- Macro: NOTE_SEQ_OCTAVE_EN.
- Defined:
  - Adds input port octave_up (1 bit), sampled in LOAD only.
  - When octave_up=1 in LOAD, the registered tone_div is the decoded value >>1 (one octave up). Rest and mute are unaffected.
- Undefined: no octave_up port; tone_div is always the base decoded value.

Test Plan:
- Reset, then ROM[0]=8'hA3 (A4, beat 3); start pulse -> two clks later BDN=3, tone_div=56818, mute=0, playing=1.
- In PLAY with ROM[1]=8'h05 (rest, beat 5): cp held high 4 clks -> rom_addr advances exactly once to 1; BDN=6, tone_div=0, mute=1.
- ROM[2]=8'h00 with loop_en=0 -> after the cp_rise that reaches address 2: DONE, done=1, playing=0, mute=1. Repeat with loop_en=1 -> rom_addr returns to 0 and ROM[0] values reload.
- No end marker, SONG_LEN=4 -> after the 4th cp_rise rom_addr wraps 3->0 and playback continues.
- stop and cp asserted in the same clk during PLAY -> IDLE, rom_addr=0, mute=1; a following cp_rise is ignored. reset asserted mid-PLAY gives identical results.
- With NOTE_SEQ_OCTAVE_EN defined, octave_up=1 and ROM word 8'hA3 -> tone_div=28409.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: walks a synchronous song ROM one word per note and decodes
// each word into a beat duration (BDN) and a tone half-period divisor.
// Advances on each rising edge of the note-change controller's cp pulse.
// Optional feature macro: NOTE_SEQ_OCTAVE_EN adds an octave_up input that
// halves the decoded tone divisor at load time.
module note_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int SONG_LEN = 32,
    parameter int CLK_HZ   = 50000000,
    parameter int TONE_W   = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              cp,
`ifdef NOTE_SEQ_OCTAVE_EN
    input  logic              octave_up,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [5:0]        BDN,
    output logic [TONE_W-1:0] tone_div,
    output logic              mute,
    output logic              playing,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    // Half-period counts, folded to constants at elaboration.
    function automatic logic [TONE_W-1:0] tone_of(input logic [3:0] code);
        logic [TONE_W-1:0] t;
        case (code)
            4'd1:    t = TONE_W'(CLK_HZ / (2 * 262));
            4'd2:    t = TONE_W'(CLK_HZ / (2 * 277));
            4'd3:    t = TONE_W'(CLK_HZ / (2 * 294));
            4'd4:    t = TONE_W'(CLK_HZ / (2 * 311));
            4'd5:    t = TONE_W'(CLK_HZ / (2 * 330));
            4'd6:    t = TONE_W'(CLK_HZ / (2 * 349));
            4'd7:    t = TONE_W'(CLK_HZ / (2 * 370));
            4'd8:    t = TONE_W'(CLK_HZ / (2 * 392));
            4'd9:    t = TONE_W'(CLK_HZ / (2 * 415));
            4'd10:   t = TONE_W'(CLK_HZ / (2 * 440));
            4'd11:   t = TONE_W'(CLK_HZ / (2 * 466));
            4'd12:   t = TONE_W'(CLK_HZ / (2 * 494));
            default: t = '0;
        endcase
        return t;
    endfunction

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        bdn_q;
    logic [TONE_W-1:0] tone_q;
    logic              mute_q;
    logic              playing_q;
    logic              done_q;
    logic              cp_q;

    logic              cp_rise;
    logic [3:0]        note_code;
    logic [2:0]        beat_code;
    logic              rest_d;
    logic              end_mark_d;
    logic [5:0]        bdn_d;
    logic [TONE_W-1:0] tone_d;
    logic              unused_rsvd;

    assign cp_rise     = cp & ~cp_q;
    assign note_code   = rom_data[7:4];
    assign beat_code   = rom_data[2:0];
    assign unused_rsvd = rom_data[3];

    // Decode the ROM word currently on rom_data into note outputs.
    always_comb begin
        rest_d     = (note_code == 4'd0) || (note_code > 4'd12);
        end_mark_d = (beat_code == 3'd0);
        case (beat_code)
            3'd1:    bdn_d = 6'd1;
            3'd2:    bdn_d = 6'd2;
            3'd3:    bdn_d = 6'd3;
            3'd4:    bdn_d = 6'd4;
            3'd5:    bdn_d = 6'd6;
            3'd6:    bdn_d = 6'd8;
            3'd7:    bdn_d = 6'd16;
            default: bdn_d = 6'd0;
        endcase
        tone_d = rest_d ? '0 : tone_of(note_code);
`ifdef NOTE_SEQ_OCTAVE_EN
        if (octave_up) tone_d = tone_d >> 1;
`endif
    end

    // Sequencer FSM with registered outputs; stop/reset override everything.
    always_ff @(posedge clk) begin
        cp_q <= cp;
        if (reset || stop) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            bdn_q     <= '0;
            tone_q    <= '0;
            mute_q    <= 1'b1;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            if (reset) cp_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        addr_q    <= '0;
                        playing_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    if (end_mark_d && loop_en) begin
                        state_q <= S_FETCH;
                        addr_q  <= '0;
                    end else if (end_mark_d) begin
                        state_q   <= S_DONE;
                        mute_q    <= 1'b1;
                        bdn_q     <= '0;
                        playing_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        state_q <= S_PLAY;
                        bdn_q   <= bdn_d;
                        tone_q  <= tone_d;
                        mute_q  <= rest_d;
                    end
                end
                S_PLAY: begin
                    if (cp_rise) begin
                        state_q <= S_FETCH;
                        addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr = addr_q;
    assign BDN      = bdn_q;
    assign tone_div = tone_q;
    assign mute     = mute_q;
    assign playing  = playing_q;
    assign done     = done_q;

endmodule
